// File: rtl/instr_encoder_rv32i_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The master drives requests and consumes words; the slave is the encoder.
interface instr_encoder_rv32i_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder_rv32i.sv
// Streaming RV32I encoder: packs decoded fields into instruction words, drops requests with
// out-of-range immediates, and queues legal words with sequential byte addresses.
module instr_encoder_rv32i #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  instr_encoder_rv32i_if.slave   bus,
  output logic [7:0]             err_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  localparam logic [2:0] FmtI = 3'b000;
  localparam logic [2:0] FmtS = 3'b001;
  localparam logic [2:0] FmtB = 3'b010;
  localparam logic [2:0] FmtU = 3'b011;
  localparam logic [2:0] FmtJ = 3'b100;
  localparam logic [2:0] FmtR = 3'b101;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        is_shift;
  logic [31:0] imm;

  assign imm      = bus.in_imm;
  assign is_shift = (bus.in_opcode == 7'h13) &&
                    ((bus.in_funct3 == 3'd1) || (bus.in_funct3 == 3'd5));

  // Range checks are done as "upper bits are a sign extension" tests instead of wide compares.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    case (bus.in_fmt)
      FmtI: begin
        if (is_shift) begin
          enc_word  = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                       bus.in_opcode};
          enc_legal = (imm[31:5] == '0);
        end else begin
          enc_word  = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
          enc_legal = (imm[31:11] == {21{imm[11]}});
        end
      end
      FmtS: begin
        enc_word  = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0],
                     bus.in_opcode};
        enc_legal = (imm[31:11] == {21{imm[11]}});
      end
      FmtB: begin
        enc_word  = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:1],
                     imm[11], bus.in_opcode};
        enc_legal = (imm[31:12] == {20{imm[12]}}) && !imm[0];
      end
      FmtU: begin
        enc_word  = {imm[31:12], bus.in_rd, bus.in_opcode};
        enc_legal = (imm[11:0] == '0);
      end
      FmtJ: begin
        enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
        enc_legal = (imm[31:20] == {12{imm[20]}}) && !imm[0];
      end
      FmtR: begin
        enc_word  = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd,
                     bus.in_opcode};
        enc_legal = 1'b1;
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b0;
      end
    endcase
  end

  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]     addr_q;
  logic [7:0]      err_q;
  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     addr_mem  [DEPTH];

  logic accept, write, drop, pop;

  // Ready depends only on the registered count, so a full FIFO never accepts on a pop cycle.
  assign bus.in_ready  = (count_q < DepthCnt);
  assign bus.out_valid = (count_q != '0);
  assign accept        = bus.in_valid && bus.in_ready && !flush;
  assign write         = accept && enc_legal;
  assign drop          = accept && !enc_legal;
  assign pop           = bus.out_valid && bus.out_ready && !flush;

  always_comb begin
    count_d = count_q;
    case ({write, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= '0;
    end else if (flush) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= '0;
    end else begin
      count_q <= count_d;
      if (write) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        addr_q   <= addr_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (drop && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (write) begin
      instr_mem[wr_ptr_q] <= enc_word;
      addr_mem[wr_ptr_q]  <= addr_q;
    end
  end

  assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr_q] : 32'h0;
  assign bus.out_addr  = bus.out_valid ? addr_mem[rd_ptr_q]  : BASE_ADDR;
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_instr_encoder_rv32i.sv
// Randomised and directed bench for instr_encoder_rv32i against a field-arithmetic model.
module tb_instr_encoder_rv32i;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] err_cnt;

  instr_encoder_rv32i_if bus ();

  instr_encoder_rv32i #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .bus    (bus),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_addr;
  int          m_err;

  // Reference encoder: fields placed by arithmetic on the immediate value.
  function automatic logic [32:0] ref_encode(logic [2:0] fmt, logic [6:0] op, logic [2:0] f3,
                                             logic [6:0] f7, logic [4:0] rd, logic [4:0] rs1,
                                             logic [4:0] rs2, logic [31:0] im);
    int          s;
    logic [31:0] w;
    bit          ok;
    s  = im;
    w  = 32'(op);
    ok = 1'b0;
    case (fmt)
      3'd0: begin
        w |= (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15);
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          ok = (s >= 0) && (s <= 31);
          w |= ((im % 32) << 20) | (32'(f7) << 25);
        end else begin
          ok = (s >= -2048) && (s <= 2047);
          w |= (im % 4096) << 20;
        end
      end
      3'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w |= ((im % 32) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20) |
             (((im / 32) % 128) << 25);
      end
      3'd2: begin
        ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
        w |= (((im / 2) % 16) << 8) | (((im / 2048) % 2) << 7) | (32'(f3) << 12) |
             (32'(rs1) << 15) | (32'(rs2) << 20) | (((im / 32) % 64) << 25) |
             (((im / 4096) % 2) << 31);
      end
      3'd3: begin
        ok = (im % 4096 == 0);
        w |= (32'(rd) << 7) | ((im / 4096) * 4096);
      end
      3'd4: begin
        ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
        w |= (32'(rd) << 7) | (((im / 4096) % 256) << 12) | (((im / 2048) % 2) << 20) |
             (((im / 2) % 1024) << 21) | (((im / 1048576) % 2) << 31);
      end
      3'd5: begin
        ok = 1'b1;
        w |= (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20) |
             (32'(f7) << 25);
      end
      default: ok = 1'b0;
    endcase
    return {ok, w};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_addr = BASE;
    m_err  = 0;
  endtask

  // Advances the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [32:0] r;
    bit          do_pop, do_push;
    if (flush) begin
      model_clear();
    end else begin
      do_pop  = (exp_q.size() != 0) && bus.out_ready;
      do_push = bus.in_valid && (exp_q.size() < DEPTH);
      r = ref_encode(bus.in_fmt, bus.in_opcode, bus.in_funct3, bus.in_funct7, bus.in_rd,
                     bus.in_rs1, bus.in_rs2, bus.in_imm);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        if (r[32]) begin
          exp_q.push_back({r[31:0], m_addr});
          m_addr = m_addr + 32'd4;
        end else if (m_err < 255) begin
          m_err++;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(logic v, logic [2:0] fmt, logic [6:0] op, logic [2:0] f3,
                         logic [6:0] f7, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                         logic [31:0] im);
    bus.in_valid  = v;
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = im;
  endtask

  task automatic do_reset();
    set_req(1'b0, 3'd0, 7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    bus.out_ready = 1'b0;
    flush = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_req(1'b0, 3'd0, 7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    bus.out_ready = 1'b0;
    flush = 1'b0;
    rst   = 1'b1;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_addr !== BASE ||
        err_cnt !== 8'h0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b i=%h a=%h e=%0d want v=0 i=0 a=%h e=0",
               bus.out_valid, bus.out_instr, bus.out_addr, err_cnt, BASE);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_addi();
    do_reset();
    set_req(1'b1, 3'd0, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL addi_pre_valid: got %b want 0", bus.out_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00500093 || bus.out_addr !== 32'h0) begin
      failures++;
      $display("FAIL addi: got v=%b i=%h a=%h want v=1 i=00500093 a=0",
               bus.out_valid, bus.out_instr, bus.out_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3];
    do_reset();
    want[0] = 32'h002081B3;
    want[1] = 32'h402081B3;
    want[2] = 32'h40315093;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: set_req(1'b1, 3'd5, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);
        1: set_req(1'b1, 3'd5, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'h0);
        default: set_req(1'b1, 3'd0, 7'h13, 3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd3);
      endcase
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== want[k] ||
          bus.out_addr !== 32'(k * 4)) begin
        failures++;
        $display("FAIL b2b_%0d: got v=%b i=%h a=%h want v=1 i=%h a=%h", k, bus.out_valid,
                 bus.out_instr, bus.out_addr, want[k], 32'(k * 4));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_formats();
    logic [31:0] want [4];
    do_reset();
    want[0] = 32'h0020A423;
    want[1] = 32'h00208463;
    want[2] = 32'h001000EF;
    want[3] = 32'h123452B7;
    set_req(1'b1, 3'd1, 7'h23, 3'd2, 7'h0, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    set_req(1'b1, 3'd2, 7'h63, 3'd0, 7'h0, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    set_req(1'b1, 3'd4, 7'h6F, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048);
    tick();
    set_req(1'b1, 3'd3, 7'h37, 3'd0, 7'h0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== want[k] ||
          bus.out_addr !== 32'(k * 4)) begin
        failures++;
        $display("FAIL fmt_%0d: got v=%b i=%h a=%h want v=1 i=%h a=%h", k, bus.out_valid,
                 bus.out_instr, bus.out_addr, want[k], 32'(k * 4));
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    do_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: set_req(1'b1, 3'd2, 7'h63, 3'd0, 7'h0, 5'd0, 5'd1, 5'd2, 32'd3);
        1: set_req(1'b1, 3'd0, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd2048);
        default: set_req(1'b1, 3'd6, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd0);
      endcase
      checks++;
      if (bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL illegal_ready_%0d: got %b want 1", k, bus.in_ready);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (err_cnt !== 8'd3 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL illegal_drop: got e=%0d v=%b want e=3 v=0", err_cnt, bus.out_valid);
    end
    set_req(1'b1, 3'd0, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_addr !== 32'h0) begin
      failures++;
      $display("FAIL illegal_next_addr: got v=%b a=%h want v=1 a=0", bus.out_valid,
               bus.out_addr);
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(1'b1, 3'd0, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'(k));
      tick();
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready: got %b want 0", bus.in_ready);
    end
    set_req(1'b1, 3'd0, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd4);
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_after_pop_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_refill_ready: got %b want 0", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== (32'h00000093 | (32'(k) << 20)) ||
          bus.out_addr !== 32'(k * 4)) begin
        failures++;
        $display("FAIL full_order_%0d: got v=%b i=%h a=%h want v=1 i=%h a=%h", k,
                 bus.out_valid, bus.out_instr, bus.out_addr,
                 32'h00000093 | (32'(k) << 20), 32'(k * 4));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    bus.out_ready = 1'b0;
    set_req(1'b1, 3'd5, 7'h33, 3'd0, 7'h0, 5'd3, 5'd1, 5'd2, 32'h0);
    tick();
    tick();
    set_req(1'b1, 3'd7, 7'h33, 3'd0, 7'h0, 5'd3, 5'd1, 5'd2, 32'h0);
    tick();
    set_req(1'b1, 3'd5, 7'h33, 3'd0, 7'h0, 5'd3, 5'd1, 5'd2, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || err_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_clear: got v=%b e=%0d r=%b want v=0 e=0 r=1", bus.out_valid,
               err_cnt, bus.in_ready);
    end
    set_req(1'b1, 3'd5, 7'h33, 3'd0, 7'h0, 5'd3, 5'd1, 5'd2, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_addr !== BASE) begin
      failures++;
      $display("FAIL flush_next_addr: got v=%b a=%h want v=1 a=%h", bus.out_valid,
               bus.out_addr, BASE);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.out_ready = 1'b0;
    set_req(1'b1, 3'd6, 7'h33, 3'd0, 7'h0, 5'd3, 5'd1, 5'd2, 32'h0);
    tick();
    set_req(1'b1, 3'd5, 7'h33, 3'd0, 7'h0, 5'd3, 5'd1, 5'd2, 32'h0);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0 || bus.out_addr !== BASE ||
        err_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: got v=%b i=%h a=%h e=%0d r=%b want v=0 i=0 a=%h e=0 r=1",
               bus.out_valid, bus.out_instr, bus.out_addr, err_cnt, bus.in_ready, BASE);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_err_saturate();
    do_reset();
    bus.out_ready = 1'b1;
    set_req(1'b1, 3'd7, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'h0);
    for (int k = 0; k < 260; k++) tick();
    bus.in_valid = 1'b0;
    checks++;
    if (err_cnt !== 8'd255 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_saturate: got e=%0d v=%b want e=255 v=0", err_cnt, bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] edges [14];
    logic [63:0] head;
    logic [31:0] im;
    edges = '{32'd2047, 32'd2048, -32'd2048, -32'd2049, 32'd4094, 32'd4095, -32'd4096,
              -32'd4098, 32'd1048574, 32'd1048576, -32'd1048576, 32'd31, 32'd32, 32'd0};
    do_reset();
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0: im = 32'($urandom_range(0, 8191)) - 32'd4096;
        1: im = $urandom;
        2: im = $urandom & 32'hFFFFF000;
        3: im = 32'($urandom_range(0, 2097151)) - 32'd1048576;
        default: im = edges[$urandom_range(0, 13)];
      endcase
      set_req(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 1) != 0) ? 7'h13 : 7'($urandom), 3'($urandom),
              7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), im);
      bus.out_ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 49) == 0);
      checks++;
      if (bus.out_valid !== (exp_q.size() != 0) || bus.in_ready !== (exp_q.size() < DEPTH) ||
          err_cnt !== 8'(m_err)) begin
        failures++;
        $display("FAIL rand_status_%0d: got v=%b r=%b e=%0d want v=%b r=%b e=%0d", n,
                 bus.out_valid, bus.in_ready, err_cnt, exp_q.size() != 0,
                 exp_q.size() < DEPTH, m_err);
      end
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        checks++;
        if (bus.out_instr !== head[63:32] || bus.out_addr !== head[31:0]) begin
          failures++;
          $display("FAIL rand_head_%0d: got i=%h a=%h want i=%h a=%h", n, bus.out_instr,
                   bus.out_addr, head[63:32], head[31:0]);
        end
      end
      tick();
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_formats();
    test_illegal();
    test_full();
    test_flush();
    test_reset_mid();
    test_err_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder_rv32i.md
Name: instr_encoder_rv32i

Overview:
- Streaming RV32I instruction encoder: takes decoded fields (format, opcode, funct3, funct7, register indices, immediate) and packs them into 32-bit instruction words.
- Inverse of the control-unit decode path.
- Feeds the instruction-memory loader and the self-check bench generator.
- Accepts requests over valid/ready, range-checks the immediate, and buffers encoded words with sequential byte addresses in an output FIFO.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, ≥2).
- BASE_ADDR, 32'h0000_0000, address of first emitted word and value after flush.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous clear of FIFO, address counter and error counter.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_fmt  in  3  I=000, S=001, B=010, U=011, J=100, R=101; 110/111 illegal.
- in_opcode  in  7  placed at [6:0].
- in_funct3  in  3  placed at [14:12] (I/S/B/R).
- in_funct7  in  7  placed at [31:25] (R; I shifts only).
- in_rd  in  5  [11:7] (R/I/U/J).
- in_rs1  in  5  [19:15] (R/I/S/B).
- in_rs2  in  5  [24:20] (R/S/B).
- in_imm  in  32  signed immediate, full byte value (U: the upper value itself).
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer pop.
- out_instr  out  32  encoded word at FIFO head.
- out_addr  out  32  byte address of head word.
- err_cnt  out  8  count of dropped illegal requests, saturating at 255.

Behaviour:
- Reset (async, rst=1): FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_cnt=0, address counter=BASE_ADDR; in_ready=1 after reset release.
- in_ready = (count < DEPTH). Registered-count based; no combinational path from out_ready. When full, a same-cycle pop does not enable a push.
- Encoding is combinational on the in_* fields. On accept:
  - Legal: word plus current address counter are written into the FIFO, and the counter += 4 (32-bit wrap, FFFF_FFFC → 0).
  - Illegal: nothing written, counter unchanged, err_cnt += 1 (saturating).
- Latency: accepted in cycle N, head visible with out_valid=1 in cycle N+1 if the FIFO was empty.
- Pop when out_valid & out_ready. out_instr/out_addr are held stable while out_valid & !out_ready.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, order preserved.
- Field packing:
  - R: f7|rs2|rs1|f3|rd|op.
  - I: imm[11:0]|rs1|f3|rd|op. Shift form (op=7'h13, f3=1 or 5): f7|imm[4:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Illegal conditions:
  - fmt 110/111.
  - I/S: imm outside [-2048, 2047].
  - I shift: imm outside [0, 31].
  - B: imm outside [-4096, 4094] or imm[0]=1.
  - J: imm outside [-1048576, 1048574] or imm[0]=1.
  - U: imm[11:0] ≠ 0.
  - R: imm ignored, always legal.
- flush: next edge empties the FIFO, sets counter=BASE_ADDR and err_cnt=0. A request accepted in the flush cycle is discarded. Flush has priority over push and pop.
- Reset mid-stream: all state is cleared immediately, and any in-flight request is lost.

Test Plan:
- Reset, then push ADDI x1,x0,5 (fmt I, op 13, f3 0, imm 5) → out_valid next cycle, out_instr=0x00500093, out_addr=0x0.
- Push back-to-back with out_ready=1:
  - ADD x3,x1,x2 → 0x002081B3, addr 0x0.
  - SUB (f7=20) → 0x402081B3, addr 0x4.
  - SRAI x1,x2,3 (f7=20) → 0x40315093, addr 0x8.
- SW x2,8(x1) → 0x0020A423; BEQ x1,x2,+8 → 0x00208463; JAL x1,+2048 → 0x001000EF; LUI x5,0x12345000 → 0x123452B7.
- Illegal cases, each with in_ready=1: BEQ imm=3; ADDI imm=2048; fmt=110. → each dropped, err_cnt=3, no out_valid, next legal word gets addr 0x0.
- Hold out_ready=0 with DEPTH=4 and push 5 → in_ready falls after the 4th accept and the 5th is held. Pop one, and the 5th is accepted the following cycle. Order and addrs 0x0..0x10 are preserved.
- Fill 2 entries, then assert flush concurrently with a push → FIFO empty, err_cnt=0, next word addr=BASE_ADDR. Separately, assert rst mid-burst → outputs at reset values immediately.
